// File: rtl/io_input_ctrl_pkg.sv
// Shared I/O address map and KCTRL bit layout for the input peripheral.
// DataMemory decode imports the same constants, so the map is defined only here.
package io_input_ctrl_pkg;

  localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;

  localparam int KCTRL_READY_BIT   = 0;
  localparam int KCTRL_OVERRUN_BIT = 2;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_KEY,
    SEL_SW,
    SEL_KCTRL
  } io_sel_e;

  function automatic io_sel_e decode_addr(input logic [31:0] addr);
    io_sel_e sel;
    case (addr)
      ADDR_KEY:   sel = SEL_KEY;
      ADDR_SW:    sel = SEL_SW;
      ADDR_KCTRL: sel = SEL_KCTRL;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/io_input_ctrl_if.sv
// MEM-stage I/O bus between the processor (master) and the input peripheral (slave).
interface io_input_ctrl_if #(
  parameter int DBITS = 32
);

  logic [DBITS-1:0] addr;
  logic             wr_en;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;
  logic             hit;

  modport master (
    output addr,
    output wr_en,
    output wdata,
    input  rdata,
    input  hit
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  wdata,
    output rdata,
    output hit
  );

endinterface

// File: rtl/io_input_ctrl_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a counting debouncer.
// db_next exposes the value db takes at the coming edge so the parent can spot edges early.
module io_input_ctrl_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db,
  output logic db_next
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;
  logic          accept;

  // A level is only accepted after it has differed from db on DEBOUNCE_CYCLES consecutive samples.
  assign accept  = (sync_b != db) && (cnt == LAST);
  assign db_next = accept ? sync_b : db;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      db     <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      db     <= db_next;
      if ((sync_b == db) || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped SW/KEY input peripheral: debounced levels, sticky key-press status,
// and a zero-latency read mux for the data-memory read path.
module io_input_ctrl
  import io_input_ctrl_pkg::*;
#(
  parameter int          DBITS           = 32,
  parameter int          SW_BITS         = 10,
  parameter int          KEY_BITS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SW_BITS-1:0]  sw_in,
  input  logic [KEY_BITS-1:0] key_in,
  io_input_ctrl_if.slave      bus
);

  logic [SW_BITS-1:0]  db_sw;
  logic [SW_BITS-1:0]  sw_db_next;
  logic [KEY_BITS-1:0] db_key;
  logic [KEY_BITS-1:0] db_key_next;

  logic       press;
  logic       ready;
  logic       overrun;
  logic       ready_next;
  logic       overrun_next;
  logic       kctrl_wr;
  logic       clr_ready;
  logic       clr_overrun;
  io_sel_e    sel;

  logic [DBITS-1:0] rd_value;
  logic             rd_hit;

  logic unused_sw_next;
  logic unused_wdata;
  assign unused_sw_next = ^sw_db_next;
  assign unused_wdata   = ^{bus.wdata[DBITS-1:KCTRL_OVERRUN_BIT+1], bus.wdata[1]};

  for (genvar i = 0; i < SW_BITS; i++) begin : g_sw
    io_input_ctrl_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (sw_in[i]),
      .db      (db_sw[i]),
      .db_next (sw_db_next[i])
    );
  end

  // Buttons are active-low on the board; invert up front so pressed reads as 1 everywhere.
  for (genvar i = 0; i < KEY_BITS; i++) begin : g_key
    io_input_ctrl_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (~key_in[i]),
      .db      (db_key[i]),
      .db_next (db_key_next[i])
    );
  end

  assign press       = |(db_key_next & ~db_key);
  assign sel         = decode_addr(32'(bus.addr));
  assign kctrl_wr    = bus.wr_en && (sel == SEL_KCTRL);
  assign clr_ready   = kctrl_wr && !bus.wdata[KCTRL_READY_BIT];
  assign clr_overrun = kctrl_wr && !bus.wdata[KCTRL_OVERRUN_BIT];

  // Software clears apply first, then a press; a press racing a clear is never lost.
  always_comb begin
    ready_next   = ready;
    overrun_next = overrun;
    if (clr_ready) begin
      ready_next = 1'b0;
    end
    if (clr_overrun) begin
      overrun_next = 1'b0;
    end
    if (press) begin
      if (ready_next) begin
        overrun_next = 1'b1;
      end
      ready_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ready   <= ready_next;
      overrun <= overrun_next;
    end
  end

  always_comb begin
    rd_value = '0;
    rd_hit   = 1'b1;
    case (sel)
      SEL_KEY:   rd_value = DBITS'(db_key);
      SEL_SW:    rd_value = DBITS'(db_sw);
      SEL_KCTRL: begin
        rd_value[KCTRL_READY_BIT]   = ready;
        rd_value[KCTRL_OVERRUN_BIT] = overrun;
      end
      default:   rd_hit = 1'b0;
    endcase
  end

  assign bus.rdata = rd_value;
  assign bus.hit   = rd_hit;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Scoreboard bench for io_input_ctrl with a short debounce window.
module tb_io_input_ctrl;
  import io_input_ctrl_pkg::*;

  localparam logic [31:0] ADDR_UNMAPPED = 32'hF000_0018;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] sw_in;
  logic [3:0] key_in;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  string       tag_q[$];

  io_input_ctrl_if #(.DBITS(32)) bus ();

  io_input_ctrl #(
    .DBITS           (32),
    .SW_BITS         (10),
    .KEY_BITS        (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_in   (sw_in),
    .key_in  (key_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [32:0] actual, input logic [32:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got hit=%0b rdata=%h, expected hit=%0b rdata=%h",
               tag, actual[32], actual[31:0], expected[32], expected[31:0]);
    end
  endtask

  function automatic logic is_mapped(input logic [31:0] a);
    return (a == ADDR_KEY) || (a == ADDR_SW) || (a == ADDR_KCTRL);
  endfunction

  task automatic sampleOutput();
    logic [32:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checkOutput(t, {bus.hit, bus.rdata}, e);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] exp_data);
    bus.addr  = a;
    bus.wr_en = 1'b0;
    exp_q.push_back({is_mapped(a), exp_data});
    tag_q.push_back(tag);
    #1;
    sampleOutput();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic press_key();
    key_in[0] = 1'b0;
    tick(8);
    key_in[0] = 1'b1;
    tick(8);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    key_in    = 4'hF;
    sw_in     = 10'h3FF;
    bus.addr  = '0;
    bus.wr_en = 1'b0;
    bus.wdata = '0;

    // Reset state with inputs already active
    #2;
    applyStimulus("rst_key",   ADDR_KEY,   32'h0);
    applyStimulus("rst_sw",    ADDR_SW,    32'h0);
    applyStimulus("rst_kctrl", ADDR_KCTRL, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(5);
    applyStimulus("sw_5clk", ADDR_SW, 32'h0);
    tick(1);
    applyStimulus("sw_6clk",       ADDR_SW,  32'h3FF);
    applyStimulus("key_after_rst", ADDR_KEY, 32'h0);

    // Short glitch must be rejected
    key_in[0] = 1'b0;
    tick(3);
    key_in[0] = 1'b1;
    tick(6);
    applyStimulus("glitch_key",   ADDR_KEY,   32'h0);
    applyStimulus("glitch_kctrl", ADDR_KCTRL, 32'h0);

    // Valid press: level appears after 6 clocks together with ready
    key_in[0] = 1'b0;
    tick(5);
    applyStimulus("press_5clk", ADDR_KEY, 32'h0);
    tick(1);
    applyStimulus("press_6clk",  ADDR_KEY,   32'h1);
    applyStimulus("press_ready", ADDR_KCTRL, 32'h1);
    tick(2);
    key_in[0] = 1'b1;
    tick(8);
    applyStimulus("release_key",   ADDR_KEY,   32'h0);
    applyStimulus("release_kctrl", ADDR_KCTRL, 32'h1);

    // Overrun and software clears
    press_key();
    applyStimulus("overrun", ADDR_KCTRL, 32'h5);
    store(ADDR_KCTRL, 32'h0);
    applyStimulus("clr_all", ADDR_KCTRL, 32'h0);
    store(ADDR_KCTRL, 32'h5);
    applyStimulus("wr1_from_zero", ADDR_KCTRL, 32'h0);
    press_key();
    press_key();
    applyStimulus("overrun_again", ADDR_KCTRL, 32'h5);
    store(ADDR_KCTRL, 32'h1);
    applyStimulus("clr_overrun_only", ADDR_KCTRL, 32'h1);
    store(ADDR_KCTRL, 32'h5);
    applyStimulus("wr1_keeps_ready", ADDR_KCTRL, 32'h1);

    // Collision: debounced press on the same edge as a clearing store
    key_in[0] = 1'b0;
    tick(5);
    bus.addr  = ADDR_KCTRL;
    bus.wdata = 32'h0;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    applyStimulus("collision_kctrl", ADDR_KCTRL, 32'h1);
    applyStimulus("collision_key",   ADDR_KEY,   32'h1);
    tick(2);
    key_in[0] = 1'b1;
    tick(8);

    // Address decode and ignored stores
    applyStimulus("unmapped_read", ADDR_UNMAPPED, 32'h0);
    applyStimulus("hit_key",       ADDR_KEY,      32'h0);
    store(ADDR_SW, 32'hFF);
    applyStimulus("sw_store_ignored", ADDR_SW, 32'h3FF);
    store(ADDR_UNMAPPED, 32'h0);
    applyStimulus("unmapped_store_ignored", ADDR_KCTRL, 32'h1);
    store(ADDR_KEY, 32'h0);
    applyStimulus("key_store_ignored", ADDR_KCTRL, 32'h1);

    // Async reset in the middle of a debounce count
    key_in[0] = 1'b0;
    tick(3);
    #1;
    reset_n = 1'b0;
    applyStimulus("midrst_key",   ADDR_KEY,   32'h0);
    applyStimulus("midrst_sw",    ADDR_SW,    32'h0);
    applyStimulus("midrst_kctrl", ADDR_KCTRL, 32'h0);
    reset_n = 1'b1;
    tick(5);
    applyStimulus("requal_5clk_key",   ADDR_KEY,   32'h0);
    applyStimulus("requal_5clk_kctrl", ADDR_KCTRL, 32'h0);
    tick(1);
    applyStimulus("requal_6clk_key",   ADDR_KEY,   32'h1);
    applyStimulus("requal_6clk_kctrl", ADDR_KCTRL, 32'h1);
    applyStimulus("requal_6clk_sw",    ADDR_SW,    32'h3FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
